// File: rtl/tdm_demux_1x4.sv
// ============================================================================
// tdm_demux_1x4 : frame-aligned 1-to-4 TDM demultiplexer, atomic output update
// Revision 1.0
// ============================================================================
`default_nettype none

module tdm_demux_1x4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             frame_valid,
  output logic             frame_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            sh0_d   = in;
            sel_d   = 2'd1;
            state_d = RECV;
          end
        end
        RECV: begin
          if (frame_start) begin
            // Restart: the partial frame is dropped, outputs keep the last full frame
            frame_err_d = 1'b1;
            sh0_d       = in;
            sel_d       = 2'd1;
          end else begin
            case (sel_q)
              2'd1: begin
                sh1_d = in;
                sel_d = 2'd2;
              end
              2'd2: begin
                sh2_d = in;
                sel_d = 2'd3;
              end
              2'd3: begin
                // Slot 3 bypasses the shadow so all four outputs load on this edge
                a_d           = sh0_q;
                b_d           = sh1_q;
                c_d           = sh2_q;
                d_d           = in;
                frame_valid_d = 1'b1;
                sel_d         = 2'd0;
                state_d       = IDLE;
              end
              default: begin
                sel_d = sel_q;
              end
            endcase
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign sel         = sel_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_1x4.sv
// ============================================================================
// tb_tdm_demux_1x4 : scoreboard bench for tdm_demux_1x4 with directed vectors
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             frame_start;
  logic [WIDTH-1:0] a, b, c, d;
  logic [1:0]       sel;
  logic             frame_valid;
  logic             frame_err;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] ec;
    logic [WIDTH-1:0] ed;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  tdm_demux_1x4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .sel         (sel),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] ea, input logic [3:0] eb,
                         input logic [3:0] ec, input logic [3:0] ed);
    chk({name, "_abcd"}, {a, b, c, d}, {ea, eb, ec, ed});
  endtask

  task automatic push(input logic err, input logic [3:0] ea, input logic [3:0] eb,
                      input logic [3:0] ec, input logic [3:0] ed);
    exp_t e;
    e.err = err; e.ea = ea; e.eb = eb; e.ec = ec; e.ed = ed;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [3:0] data, input logic fs);
    in          = data;
    in_valid    = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && frame_err) begin
        n_chk++;
        n_fail++;
        $display("FAIL pulse_overlap: frame_valid=1 frame_err=1 at %0t", $time);
      end else if (frame_valid || frame_err) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: fv=%0b fe=%0b abcd=%h, none expected at %0t",
                   frame_valid, frame_err, {a, b, c, d}, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (frame_err !== e.err || {a, b, c, d} !== {e.ea, e.eb, e.ec, e.ed}) begin
            n_fail++;
            $display("FAIL scoreboard: got err=%0b abcd=%h expected err=%0b abcd=%h at %0t",
                     frame_err, {a, b, c, d}, e.err, {e.ea, e.eb, e.ec, e.ed}, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    in          = '0;
    in_valid    = 1'b0;
    frame_start = 1'b0;

    // Reset with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      in          = 4'($urandom);
      in_valid    = 1'($urandom);
      frame_start = 1'($urandom);
      @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 0, 0);
      chk("reset_sel", sel, 0);
      chk("reset_pulses", {frame_valid, frame_err}, 0);
    end
    in_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Beats without frame_start in IDLE are ignored
    beat(4'd7, 1'b0);
    beat(4'd9, 1'b0);
    chk("idle_sel", sel, 0);
    chk_out("idle", 0, 0, 0, 0);

    // Normal frame on consecutive cycles
    beat(4'd1, 1'b1); chk("norm_sel1", sel, 1);
    beat(4'd2, 1'b0); chk("norm_sel2", sel, 2);
    beat(4'd3, 1'b0); chk("norm_sel3", sel, 3);
    chk_out("norm_hold", 0, 0, 0, 0);
    push(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    beat(4'd4, 1'b0); chk("norm_sel0", sel, 0);
    chk("norm_fv", frame_valid, 1);
    chk_out("norm", 1, 2, 3, 4);
    idle(1);
    chk("norm_fv_drop", frame_valid, 0);

    // Frame with idle gaps between beats
    beat(4'd5, 1'b1); idle(2);
    beat(4'd6, 1'b0); idle(3);
    chk_out("gap_hold1", 1, 2, 3, 4);
    beat(4'd7, 1'b0);
    chk_out("gap_hold2", 1, 2, 3, 4);
    chk("gap_sel", sel, 3);
    push(1'b0, 4'd5, 4'd6, 4'd7, 4'd8);
    beat(4'd8, 1'b0);
    chk_out("gap", 5, 6, 7, 8);
    idle(2);

    // frame_start with in_valid=0 is ignored
    in = 4'd3; frame_start = 1'b1; idle(1); frame_start = 1'b0;
    chk("fs_novalid_sel", sel, 0);

    // Abort: restart after two slots
    beat(4'd9, 1'b1);
    beat(4'd10, 1'b0);
    push(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
    beat(4'd11, 1'b1);
    chk("abort_fe", frame_err, 1);
    chk("abort_sel", sel, 1);
    chk_out("abort_hold", 5, 6, 7, 8);
    beat(4'd12, 1'b0);
    beat(4'd13, 1'b0);
    push(1'b0, 4'd11, 4'd12, 4'd13, 4'd14);
    beat(4'd14, 1'b0);
    chk_out("abort_done", 11, 12, 13, 14);

    // Abort at sel=3 must not complete
    beat(4'd1, 1'b1); beat(4'd1, 1'b0); beat(4'd1, 1'b0);
    push(1'b1, 4'd11, 4'd12, 4'd13, 4'd14);
    beat(4'd2, 1'b1);
    chk("abort3_fv", frame_valid, 0);
    chk_out("abort3_hold", 11, 12, 13, 14);
    beat(4'd3, 1'b0); beat(4'd4, 1'b0);
    push(1'b0, 4'd2, 4'd3, 4'd4, 4'd5);
    beat(4'd5, 1'b0);
    chk_out("abort3_done", 2, 3, 4, 5);

    // Back-to-back frames, continuous valid
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 3)
        push(1'b0, 4'(i - 3), 4'(i - 2), 4'(i - 1), 4'(i));
      beat(4'(i), (i % 4) == 0);
      chk("b2b_fv", frame_valid, (i % 4) == 3);
    end
    chk_out("b2b_last", 12, 13, 14, 15);

    // Async reset mid-frame, between edges
    beat(4'd6, 1'b1); beat(4'd7, 1'b0); beat(4'd8, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 0, 0, 0, 0);
    chk("mid_reset_sel", sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    beat(4'd1, 1'b0);
    chk("post_reset_sel", sel, 0);
    beat(4'd2, 1'b1); beat(4'd3, 1'b0); beat(4'd4, 1'b0);
    push(1'b0, 4'd2, 4'd3, 4'd4, 4'd5);
    beat(4'd5, 1'b0);
    chk_out("post_reset", 2, 3, 4, 5);
    idle(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-side counterpart of the 4x1 selector: takes a time-division-multiplexed word stream (one slot per valid beat) and distributes slots 0..3 to four registered channel outputs a, b, c, d.
- Frame-aligned by a start marker; shadow registers ensure all four outputs update atomically once per complete frame.
- Sits at the far end of a link whose transmit side serialises four channels through the library 4x1 mux under a rotating select.

Parameters:
- WIDTH, 4, bit width of each slot and each channel output (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  TDM slot data.
- in_valid  input  1  slot beat qualifier; data accepted on any rising edge with in_valid=1.
- frame_start  input  1  marks slot 0; meaningful only when in_valid=1.
- a  output  WIDTH  channel 0 (slot 0) of last complete frame.
- b  output  WIDTH  channel 1 (slot 1).
- c  output  WIDTH  channel 2 (slot 2).
- d  output  WIDTH  channel 3 (slot 3).
- sel  output  2  slot index expected next (0 in IDLE).
- frame_valid  output  1  one-cycle pulse: a..d just updated.
- frame_err  output  1  one-cycle pulse: partial frame aborted by a new frame_start.

Behaviour:
- Reset (rst_n=0, async): a=b=c=d=0, shadow regs=0, sel=0, frame_valid=0, frame_err=0, state=IDLE. Takes effect immediately. Any partial frame is discarded with no pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- "Beat" = rising edge with in_valid=1. Edges with in_valid=0 change nothing except clearing the pulses; gaps of any length are allowed mid-frame.
- States:
  - IDLE: beat with frame_start=1 stores in to shadow0, sel<=1, goes to RECV. Beat with frame_start=0 is ignored (stays IDLE, sel=0).
  - RECV: beat with frame_start=0 stores in to shadow[sel].
    - sel=1: sel<=2.
    - sel=2: sel<=3.
    - sel=3 (frame completion): a<=shadow0, b<=shadow1, c<=shadow2, d<=in, frame_valid<=1, sel<=0, state<=IDLE.
  - RECV: beat with frame_start=1 (any sel, including 3) aborts the partial frame. frame_err<=1, in stored to shadow0, sel<=1, stays RECV. a..d are unchanged.
- frame_start with in_valid=0 is ignored in all states.
- Latency: a..d and frame_valid change on the same edge that accepts slot 3, so both are visible in the following cycle. frame_valid is high for exactly one cycle, then returns to 0 unless another completion occurs.
- Back-to-back frames: frame_start beat on the cycle right after completion (state IDLE) starts a new frame with no bubble. Continuous valid traffic gives one frame_valid every 4 cycles.
- a..d hold their values between completions, even across aborts and gaps.
- frame_valid and frame_err are never both high in the same cycle.
- sel wraps only through completion (3 -> 0); it never increments past 3.

Test Plan:
- Reset: hold rst_n=0 with random in/in_valid -> a=b=c=d=0, sel=0, frame_valid=0, frame_err=0. Release, then send idle beats without frame_start -> outputs unchanged, sel=0.
- Normal frame: beats 1(fs=1),2,3,4 on consecutive cycles -> one cycle after 4th edge a=1 b=2 c=3 d=4, frame_valid=1 for exactly one cycle; sel sequence 1,2,3,0.
- Gaps: beats 5(fs),6,7,8 separated by 0-3 idle cycles -> a..d hold 1,2,3,4 until the final beat, then become 5,6,7,8 atomically; single frame_valid pulse.
- Abort: beats 9(fs),10, then frame_start beat 11, then 12,13,14 -> frame_err pulses once on the restart, a..d keep previous frame until completion, then a=11 b=12 c=13 d=14; no frame_valid for the aborted frame.
- Back-to-back: continuous in_valid with fs every 4th beat, data 0..15 (WIDTH=4) -> four frame_valid pulses spaced 4 cycles apart; outputs (0,1,2,3),(4,5,6,7),(8,9,10,11),(12,13,14,15).
- Reset mid-frame: assert rst_n=0 asynchronously (between edges) after slot 2 of a frame -> immediate clear of all outputs. After release, beats 1(no fs),2(fs),3,4,5 -> a=2 b=3 c=4 d=5; the leading beat is ignored.
